// File: rtl/elevador_pkg.sv
// Shared types and helpers for the elevator call scheduler.
package elevador_pkg;

    localparam int N_FLOORS_DEF = 5;
    localparam int FLOOR_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPATCH = 2'd2,
        DOOR     = 2'd3
    } state_t;

    // Out-of-range floors encode to all-zero.
    function automatic logic [N_FLOORS_DEF-1:0] onehot(
        input logic [FLOOR_W_DEF-1:0] f
    );
        logic [N_FLOORS_DEF-1:0] v;
        v = '0;
        v[0] = 1'b1;
        return v << f;
    endfunction

endpackage

// File: rtl/elevator_scan_select.sv
// SCAN target picker: nearest pending floor in the travel direction.
module elevator_scan_select #(
    parameter int N_FLOORS = 5,
    parameter int FLOOR_W  = 3
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                dir_up,
    output logic                found,
    output logic [FLOOR_W-1:0]  target,
    output logic                new_dir
);

    logic               up_hit;
    logic               dn_hit;
    logic [FLOOR_W-1:0] up_idx;
    logic [FLOOR_W-1:0] dn_idx;

    // Lowest at/above and highest at/below; the later loop hit wins.
    always_comb begin
        up_hit = 1'b0;
        dn_hit = 1'b0;
        up_idx = '0;
        dn_idx = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= current_floor)) begin
                up_hit = 1'b1;
                up_idx = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) <= current_floor)) begin
                dn_hit = 1'b1;
                dn_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found   = up_hit | dn_hit;
        target  = '0;
        new_dir = dir_up;
        if (dir_up) begin
            if (up_hit) begin
                target  = up_idx;
                new_dir = 1'b1;
            end else if (dn_hit) begin
                target  = dn_idx;
                new_dir = 1'b0;
            end
        end else begin
            if (dn_hit) begin
                target  = dn_idx;
                new_dir = 1'b0;
            end else if (up_hit) begin
                target  = up_idx;
                new_dir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls and sequences the elevator core in SCAN order,
// holding the doors open for a fixed time at every stop.
module elevator_call_scheduler
    import elevador_pkg::*;
#(
    parameter int N_FLOORS    = N_FLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                motor_up,
    input  logic                motor_down,
    output logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                door_open,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending,
    output logic                served
);

    localparam int CNT_W = $clog2(DOOR_CYCLES) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [N_FLOORS-1:0] pending_nx;
    logic [FLOOR_W-1:0]  target_nx;
    logic                dir_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                arrive;
    logic [N_FLOORS-1:0] here;
    logic [N_FLOORS-1:0] tgt_oh;
    logic                sel_found;
    logic [FLOOR_W-1:0]  sel_target;
    logic                sel_dir;

    assign arrive = (current_floor == target_floor) & ~motor_up & ~motor_down;
    assign here   = onehot(current_floor);
    assign tgt_oh = onehot(target_floor);

    elevator_scan_select #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_scan (
        .pending       (pending),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .found         (sel_found),
        .target        (sel_target),
        .new_dir       (sel_dir)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            dir_up       <= 1'b1;
            cnt          <= '0;
        end else begin
            state        <= state_nx;
            pending      <= pending_nx;
            target_floor <= target_nx;
            dir_up       <= dir_nx;
            cnt          <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pending_nx = pending | call_btn;
        target_nx  = target_floor;
        dir_nx     = dir_up;
        cnt_nx     = cnt;
        req        = '0;
        door_open  = 1'b0;
        served     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pending) state_nx = SELECT;
            end
            SELECT: begin
                if (sel_found) begin
                    target_nx = sel_target;
                    dir_nx    = sel_dir;
                    state_nx  = DISPATCH;
                end else begin
                    state_nx  = IDLE;
                end
            end
            DISPATCH: begin
                req = tgt_oh;
                if (arrive) begin
                    // Clearing wins over a same-cycle call to the target.
                    pending_nx = (pending | call_btn) & ~tgt_oh;
                    served     = 1'b1;
                    cnt_nx     = RELOAD;
                    state_nx   = DOOR;
                end
            end
            DOOR: begin
                door_open  = 1'b1;
                pending_nx = pending | (call_btn & ~here);
                if (|(call_btn & here)) begin
                    cnt_nx = RELOAD;
                end else if (cnt == '0) begin
                    state_nx = (|pending_nx) ? SELECT : IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler; the bench plays the core.
module tb_elevator_call_scheduler;

    logic       clk;
    logic       reset;
    logic [4:0] call_btn;
    logic [2:0] current_floor;
    logic       motor_up;
    logic       motor_down;
    logic [4:0] req;
    logic [2:0] target_floor;
    logic       door_open;
    logic       dir_up;
    logic [4:0] pending;
    logic       served;

    int checks;
    int errors;

    elevator_call_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .req           (req),
        .target_floor  (target_floor),
        .door_open     (door_open),
        .dir_up        (dir_up),
        .pending       (pending),
        .served        (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (req === 5'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req === 5'b0) begin
            errors++;
            $display("FAIL %s: req timeout, got %b want nonzero", tag, req);
        end
    endtask

    task automatic wait_door_closed(input string tag);
        int k;
        k = 0;
        while (door_open !== 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (door_open !== 1'b0) begin
            errors++;
            $display("FAIL %s: door timeout, got %b want 0", tag, door_open);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        call_btn = '0;
        current_floor = '0;
        motor_up = 1'b0;
        motor_down = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req, door_open, served, pending} !== 12'b0) begin
            errors++;
            $display("FAIL reset_out: got req=%b door=%b srv=%b pend=%b want 0",
                     req, door_open, served, pending);
        end
        checks++;
        if (target_floor !== 3'd0 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL reset_reg: got tgt=%0d dir=%b want 0/1", target_floor, dir_up);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        current_floor = 3'd0;
        call_btn = 5'b01000;
        @(negedge clk);
        call_btn = '0;
        checks++;
        if (pending !== 5'b01000 || req !== 5'b0) begin
            errors++;
            $display("FAIL lat_1: got pend=%b req=%b want 01000/00000", pending, req);
        end
        @(negedge clk);
        checks++;
        if (req !== 5'b0) begin
            errors++;
            $display("FAIL lat_2: got req=%b want 00000", req);
        end
        @(negedge clk);
        checks++;
        if (req !== 5'b01000 || target_floor !== 3'd3 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL lat_3: got req=%b tgt=%0d dir=%b want 01000/3/1",
                     req, target_floor, dir_up);
        end
    endtask

    task automatic test_arrival();
        int n;
        current_floor = 3'd3;
        #1;
        checks++;
        if (served !== 1'b1 || req !== 5'b01000) begin
            errors++;
            $display("FAIL arr_served: got srv=%b req=%b want 1/01000", served, req);
        end
        @(negedge clk);
        checks++;
        if (pending !== 5'b0 || served !== 1'b0) begin
            errors++;
            $display("FAIL arr_clear: got pend=%b srv=%b want 0/0", pending, served);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (door_open === 1'b1) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arr_door_len: got %0d want 4", n);
        end
    endtask

    task automatic test_scan();
        current_floor = 3'd2;
        call_btn = 5'b10001;
        @(negedge clk);
        call_btn = '0;
        wait_req("scan_first");
        checks++;
        if (req !== 5'b10000 || target_floor !== 3'd4 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL scan_first: got req=%b tgt=%0d dir=%b want 10000/4/1",
                     req, target_floor, dir_up);
        end
        current_floor = 3'd4;
        @(negedge clk);
        wait_req("scan_second");
        checks++;
        if (req !== 5'b00001 || target_floor !== 3'd0 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL scan_second: got req=%b tgt=%0d dir=%b want 00001/0/0",
                     req, target_floor, dir_up);
        end
        current_floor = 3'd0;
        @(negedge clk);
        wait_door_closed("scan_done");
        checks++;
        if (pending !== 5'b0) begin
            errors++;
            $display("FAIL scan_pend: got %b want 00000", pending);
        end
    endtask

    task automatic test_door_extend();
        int n;
        bit done;
        bit leaked;
        call_btn = 5'b01000;
        @(negedge clk);
        call_btn = '0;
        wait_req("ext_req");
        checks++;
        if (req !== 5'b01000 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL ext_dispatch: got req=%b dir=%b want 01000/1", req, dir_up);
        end
        current_floor = 3'd3;
        @(negedge clk);
        n = 0;
        done = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (door_open === 1'b1) n++;
            if (n == 2 && !done) begin
                call_btn = 5'b01000;
                done = 1'b1;
            end else begin
                call_btn = '0;
            end
            @(negedge clk);
            if (pending[3] !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL ext_latch: got pending[3]=1 want 0");
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL ext_door_len: got %0d want 6", n);
        end
    endtask

    task automatic test_arrive_call();
        int sv;
        call_btn = 5'b00010;
        @(negedge clk);
        call_btn = '0;
        wait_req("ac_req");
        checks++;
        if (req !== 5'b00010 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL ac_dispatch: got req=%b dir=%b want 00010/0", req, dir_up);
        end
        current_floor = 3'd1;
        call_btn = 5'b00010;
        #1;
        sv = (served === 1'b1) ? 1 : 0;
        @(negedge clk);
        call_btn = '0;
        checks++;
        if (pending !== 5'b0) begin
            errors++;
            $display("FAIL ac_clear: got pend=%b want 00000", pending);
        end
        for (int i = 0; i < 10; i++) begin
            if (served === 1'b1) sv++;
            @(negedge clk);
        end
        checks++;
        if (sv != 1) begin
            errors++;
            $display("FAIL ac_served: got %0d pulses want 1", sv);
        end
    endtask

    task automatic test_reset_dispatch();
        call_btn = 5'b00001;
        @(negedge clk);
        call_btn = '0;
        wait_req("rd_req");
        checks++;
        if (req !== 5'b00001 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL rd_dispatch: got req=%b dir=%b want 00001/0", req, dir_up);
        end
        call_btn = 5'b10000;
        @(negedge clk);
        call_btn = '0;
        reset = 1'b1;
        #1;
        checks++;
        if (req !== 5'b0 || pending !== 5'b0 || dir_up !== 1'b1 || target_floor !== 3'd0) begin
            errors++;
            $display("FAIL rd_clear: got req=%b pend=%b dir=%b tgt=%0d want 0/0/1/0",
                     req, pending, dir_up, target_floor);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req !== 5'b0 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle: got req=%b door=%b want 0/0", req, door_open);
        end
    endtask

    task automatic test_out_of_range();
        current_floor = 3'd7;
        call_btn = 5'b00100;
        @(negedge clk);
        call_btn = '0;
        wait_req("oor_req");
        checks++;
        if (req !== 5'b00100 || target_floor !== 3'd2 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL oor_sel: got req=%b tgt=%0d dir=%b want 00100/2/0",
                     req, target_floor, dir_up);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_arrival();
        test_scan();
        test_door_extend();
        test_arrive_call();
        test_reset_dispatch();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
